// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, hex decode and the display config record
// used by the shadow and active sets of the scan controller.
package seg7_pkg;
   localparam int MAX_DIG = 16;
   localparam int MAX_PWM = 8;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Sized for the largest supported geometry; narrower instances zero-extend.
   typedef struct packed {
      logic [MAX_DIG*8-1:0] data;
      logic [MAX_DIG-1:0]   dp;
      logic [MAX_DIG-1:0]   blink;
      logic                 blank_lz;
      logic                 mode;
      logic [MAX_PWM-1:0]   bright;
   } disp_cfg_t;

   function automatic logic [7:0] hex2seg(input logic [3:0] i_hex);
      case (i_hex)
         4'h0: hex2seg = 8'hC0;
         4'h1: hex2seg = 8'hF9;
         4'h2: hex2seg = 8'hA4;
         4'h3: hex2seg = 8'hB0;
         4'h4: hex2seg = 8'h99;
         4'h5: hex2seg = 8'h92;
         4'h6: hex2seg = 8'h82;
         4'h7: hex2seg = 8'hF8;
         4'h8: hex2seg = 8'h80;
         4'h9: hex2seg = 8'h90;
         4'hA: hex2seg = 8'h88;
         4'hB: hex2seg = 8'h83;
         4'hC: hex2seg = 8'hC6;
         4'hD: hex2seg = 8'hA1;
         4'hE: hex2seg = 8'h86;
         default: hex2seg = 8'h8E;
      endcase
   endfunction
endpackage

// File: rtl/seg7_lz_blank.sv
// seg7_lz_blank: flags digits that are leading zeros; digit 0 is never blanked.
module seg7_lz_blank #(
   parameter int NUM_DIG = 8
)(
   input  logic [NUM_DIG*4-1:0] i_nib,
   output logic [NUM_DIG-1:0]   o_blank
);
   logic w_run;

   always_comb begin
      w_run   = 1'b1;
      o_blank = '0;
      for (int k = NUM_DIG - 1; k >= 0; k--) begin
         w_run      = w_run && (i_nib[4*k +: 4] == 4'd0);
         o_blank[k] = w_run && (k != 0);
      end
   end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode 7-segment scanner with double-buffered
// config, leading-zero blanking, blink, PWM dimming and anti-ghost gaps.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIG = 8,
   parameter int DIV_W   = 15,
   parameter int PWM_W   = 4,
   parameter int BLINK_W = 24
)(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 disp_mode,
   input  logic [NUM_DIG*8-1:0] i_data,
   input  logic [NUM_DIG-1:0]   i_dp,
   input  logic [NUM_DIG-1:0]   i_blink_mask,
   input  logic                 i_blank_lz,
   input  logic [PWM_W-1:0]     i_bright,
   input  logic                 i_load,
   output logic [7:0]           o_seg,
   output logic [NUM_DIG-1:0]   o_sel,
   output logic                 o_frame
);
   localparam int IW = $clog2(NUM_DIG);

   logic [DIV_W-1:0]   r_cnt;
   logic [BLINK_W:0]   r_blink;
   logic [IW-1:0]      r_idx;
   disp_cfg_t          r_shadow, r_active;
   logic               r_valid;

   logic               w_tick, w_wrap, w_on, w_blank, w_unused_cfg;
   logic [3:0]         w_nib;
   logic [7:0]         w_code;
   logic [NUM_DIG-1:0] w_lz;

   seg7_lz_blank #(.NUM_DIG(NUM_DIG)) u_lz (
      .i_nib   (r_active.data[NUM_DIG*4-1:0]),
      .o_blank (w_lz)
   );

   assign w_tick  = &r_cnt;
   assign w_wrap  = w_tick && (r_idx == IW'(NUM_DIG - 1));
   assign w_nib   = r_active.data[r_idx*4 +: 4];
   assign w_code  = r_active.mode ? r_active.data[r_idx*8 +: 8]
                                  : hex2seg(w_nib) & {~r_active.dp[r_idx], 7'h7F};
   assign w_blank = (!r_active.mode && r_active.blank_lz && w_lz[r_idx])
                 || (r_blink[BLINK_W] && r_active.blink[r_idx]);
   // The tick cycle is a dead gap so the next digit never sees stale segments.
   assign w_on    = !w_tick && (r_cnt[DIV_W-1 -: PWM_W] < r_active.bright[PWM_W-1:0]);
   assign w_unused_cfg = ^r_active;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt    <= '0;
         r_blink  <= '0;
         r_idx    <= '0;
         r_shadow <= '0;
         r_active <= '0;
         r_valid  <= 1'b0;
         o_seg    <= SEG_BLANK;
         o_sel    <= '1;
         o_frame  <= 1'b0;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
         r_blink <= r_blink + 1'b1;
         if (w_tick) r_idx <= w_wrap ? '0 : r_idx + 1'b1;
         if (w_wrap && r_valid) r_active <= r_shadow;
         if (i_load) r_shadow <= '{data: (MAX_DIG*8)'(i_data), dp: MAX_DIG'(i_dp),
                                   blink: MAX_DIG'(i_blink_mask), blank_lz: i_blank_lz,
                                   mode: disp_mode, bright: MAX_PWM'(i_bright)};
         // A load on the swap edge survives as pending for the following frame.
         r_valid <= i_load || (r_valid && !w_wrap);
         o_frame <= w_wrap;
         o_sel   <= w_on ? ~(NUM_DIG'(1) << r_idx) : '1;
         o_seg   <= (w_on && !w_blank) ? w_code : SEG_BLANK;
      end
   end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed scenarios for the scan controller with a
// queue of expected per-slot digits checked against the scanned outputs.
module tb_seg7_scan_ctrl;
   logic        clk = 1'b0, rstn = 1'b0, disp_mode = 1'b0, i_blank_lz = 1'b0, i_load = 1'b0;
   logic [31:0] i_data = '0;
   logic [3:0]  i_dp = '0, i_blink_mask = '0;
   logic [1:0]  i_bright = '0;
   logic [7:0]  o_seg;
   logic [3:0]  o_sel;
   logic        o_frame;

   int n_tests = 0, n_fail = 0, g_m = 0, cyc = 0, n = 0, ph = 0;
   bit seen0 = 0, seen1 = 0;

   typedef struct packed {logic [3:0] sel; logic [7:0] seg;} exp_t;
   exp_t q[$];

   seg7_scan_ctrl #(.NUM_DIG(4), .DIV_W(4), .PWM_W(2), .BLINK_W(6)) dut (
      .clk(clk), .rstn(rstn), .disp_mode(disp_mode), .i_data(i_data), .i_dp(i_dp),
      .i_blink_mask(i_blink_mask), .i_blank_lz(i_blank_lz), .i_bright(i_bright),
      .i_load(i_load), .o_seg(o_seg), .o_sel(o_sel), .o_frame(o_frame)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      g_m++;
   endtask

   task automatic goto(input int t);
      while (g_m < t) step();
   endtask

   task automatic load(input logic [31:0] d, input logic [3:0] dp, input logic [3:0] mask,
                       input logic blz, input logic mode, input logic [1:0] br);
      i_data = d; i_dp = dp; i_blink_mask = mask; i_blank_lz = blz; disp_mode = mode; i_bright = br;
      i_load = 1'b1;
      step();
      i_load = 1'b0;
   endtask

   task automatic wait_frame(output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!o_frame && cnt < 300);
      chk("frame_seen", 32'(o_frame), 32'd1);
      g_m = 0;
   endtask

   task automatic push(input logic [3:0] sel, input logic [7:0] seg);
      q.push_back('{sel: sel, seg: seg});
   endtask

   // Starts on the o_frame cycle; slot k cnt 4 is seen at interval 16k+5, its tick at 16k+16.
   task automatic run_frame(input string tag, input int nld, input logic [31:0] d1, input logic [31:0] d2);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         goto(16*k + 5);
         chk({tag, "_sb"}, 32'(q.size() != 0), 32'd1);
         e = (q.size() != 0) ? q.pop_front() : '1;
         chk($sformatf("%s_sel%0d", tag, k), 32'(o_sel), 32'(e.sel));
         chk($sformatf("%s_seg%0d", tag, k), 32'(o_seg), 32'(e.seg));
         chk($sformatf("%s_nofr%0d", tag, k), 32'(o_frame), 32'd0);
         if (k == 1 && nld > 0) load(d1, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3);
         if (k == 1 && nld > 1) load(d2, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3);
         goto(16*k + 16);
         chk($sformatf("%s_gap%0d", tag, k), 32'(o_sel), 32'hF);
      end
      chk({tag, "_wrap"}, 32'(o_frame), 32'd1);
      g_m = 0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_seg", 32'(o_seg), 32'hFF);
      chk("rst_sel", 32'(o_sel), 32'hF);
      chk("rst_frame", 32'(o_frame), 32'd0);
      rstn = 1'b1;
      g_m = 0;

      load(32'h1234, 4'b0100, 4'h0, 1'b0, 1'b0, 2'd3);
      wait_frame(n);
      push(4'hE, 8'h99); push(4'hD, 8'hB0); push(4'hB, 8'h24); push(4'h7, 8'hF9);
      run_frame("t1", 0, 0, 0);

      load(32'h0050, 4'h0, 4'h0, 1'b1, 1'b0, 2'd3);
      wait_frame(n);
      push(4'hE, 8'hC0); push(4'hD, 8'h92); push(4'hB, 8'hFF); push(4'h7, 8'hFF);
      run_frame("t2a", 0, 0, 0);
      load(32'h0000, 4'h0, 4'h0, 1'b1, 1'b0, 2'd3);
      wait_frame(n);
      push(4'hE, 8'hC0); push(4'hD, 8'hFF); push(4'hB, 8'hFF); push(4'h7, 8'hFF);
      run_frame("t2b", 0, 0, 0);

      load(32'h00FF7F3F, 4'hF, 4'h0, 1'b0, 1'b1, 2'd3);
      wait_frame(n);
      push(4'hE, 8'h3F); push(4'hD, 8'h7F); push(4'hB, 8'hFF); push(4'h7, 8'h00);
      run_frame("t3", 0, 0, 0);

      load(32'h1234, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3);
      wait_frame(n);
      push(4'hE, 8'h99); push(4'hD, 8'hB0); push(4'hB, 8'hA4); push(4'h7, 8'hF9);
      run_frame("t4a", 1, 32'hAAAA, 0);
      push(4'hE, 8'h88); push(4'hD, 8'h88); push(4'hB, 8'h88); push(4'h7, 8'h88);
      run_frame("t4b", 2, 32'h1111, 32'h4321);
      push(4'hE, 8'hF9); push(4'hD, 8'hA4); push(4'hB, 8'hB0); push(4'h7, 8'h99);
      run_frame("t4c", 0, 0, 0);

      load(32'h4321, 4'h0, 4'h0, 1'b0, 1'b0, 2'd1);
      wait_frame(n);
      goto(2);  chk("pwm1_on0_sel", 32'(o_sel), 32'hE); chk("pwm1_on0_seg", 32'(o_seg), 32'hF9);
      goto(6);  chk("pwm1_off0_sel", 32'(o_sel), 32'hF); chk("pwm1_off0_seg", 32'(o_seg), 32'hFF);
      goto(18); chk("pwm1_on1_sel", 32'(o_sel), 32'hD); chk("pwm1_on1_seg", 32'(o_seg), 32'hA4);
      goto(22); chk("pwm1_off1_sel", 32'(o_sel), 32'hF);
      load(32'h4321, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0);
      wait_frame(n);
      for (int t = 1; t <= 57; t += 8) begin
         goto(t);
         chk($sformatf("pwm0_sel_%0d", t), 32'(o_sel), 32'hF);
      end

      load(32'h4321, 4'h0, 4'b0001, 1'b0, 1'b0, 2'd3);
      wait_frame(n);
      for (int f = 0; f < 4; f++) begin
         goto(64*f + 5);
         ph = ((cyc - 1) >> 6) & 1;
         if (ph == 1) seen1 = 1; else seen0 = 1;
         chk($sformatf("blink_d0_%0d", f), 32'(o_seg), ph == 1 ? 32'hFF : 32'hF9);
         goto(64*f + 21);
         chk($sformatf("blink_d1_%0d", f), 32'(o_seg), 32'hA4);
      end
      chk("blink_both_phases", 32'(seen0 && seen1), 32'd1);

      wait_frame(n);
      goto(37);
      chk("pre_rst_sel", 32'(o_sel), 32'hB);
      chk("pre_rst_seg", 32'(o_seg), 32'hB0);
      load(32'h8888, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3);
      rstn = 1'b0;
      #1;
      chk("arst_seg", 32'(o_seg), 32'hFF);
      chk("arst_sel", 32'(o_sel), 32'hF);
      chk("arst_frame", 32'(o_frame), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      wait_frame(n);
      chk("restart_frame_cycles", 32'(n), 32'd64);
      for (int t = 5; t <= 53; t += 16) begin
         goto(t);
         chk($sformatf("discard_sel_%0d", t), 32'(o_sel), 32'hF);
         chk($sformatf("discard_seg_%0d", t), 32'(o_seg), 32'hFF);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
